instruction_fetch_unit: RTL and testbench

Fetch controller that sequences the instruction memory for the RISC-V core. Holds the fetch PC and issues word-aligned read requests over a req/gnt/rvalid handshake. Buffers returned instructions with their PCs in a 2-entry queue and presents them to decode with valid/ready. Handles branch/jump redirects, discarding stale in-flight responses.

---
 rtl/instruction_fetch_unit.sv | 96 +++++++++
 tb/tb_instruction_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: holds the fetch PC, issues one word-aligned read at a time over
// req/gnt/rvalid, queues returned words with their PCs for decode, and handles redirects.
module instruction_fetch_unit #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000,
    parameter int               BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            if_fault
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(BUF_DEPTH);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN, S_FAULT} state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] r_buf_instr [BUF_DEPTH];
    logic [XLEN-1:0] r_buf_pc    [BUF_DEPTH];
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_wr;
    logic [AW:0]     r_count;
    logic            r_fault;

    logic w_fire;
    logic w_push;
    logic w_pop;
    logic w_misalign;
    logic w_inflight;

    assign imem_req   = reset_n && r_state == S_FETCH && r_count < FULL && !redirect_valid;
    assign imem_addr  = r_fetch_pc;
    assign w_fire     = imem_req && imem_gnt;
    assign w_push     = r_state == S_WAIT && imem_rvalid && !redirect_valid;
    assign w_pop      = if_valid && id_ready && !redirect_valid;
    assign w_misalign = redirect_pc[1:0] != 2'b00;
    // A response arriving in the redirect cycle itself is simply dropped, nothing left to drain.
    assign w_inflight = ((r_state == S_WAIT || r_state == S_DRAIN) && !imem_rvalid) ||
                        (r_state == S_FETCH && imem_gnt);

    assign if_valid = r_count != '0;
    assign if_instr = if_valid ? r_buf_instr[r_rd] : '0;
    assign if_pc    = if_valid ? r_buf_pc[r_rd] : '0;
    assign if_fault = r_fault;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_FETCH;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
            r_fault    <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_fault    <= w_misalign;
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
            r_state    <= w_inflight ? S_DRAIN : (w_misalign ? S_FAULT : S_FETCH);
        end else begin
            if (w_fire) begin
                r_req_pc   <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_state <= w_fire                                ? S_WAIT :
                       (r_state == S_WAIT  && imem_rvalid)   ? S_FETCH :
                       (r_state == S_DRAIN && imem_rvalid)   ? (r_fault ? S_FAULT : S_FETCH) :
                                                               r_state;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_instr[r_wr] <= imem_rdata;
            r_buf_pc[r_wr]    <= r_req_pc;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scenarios plus a randomized run checked against a
// PC-stream scoreboard; a background process plays the instruction memory.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        imem_req, if_valid, if_fault;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0, redirect_valid = 1'b0, id_ready = 1'b0;
    logic [31:0] imem_addr, if_instr, if_pc;
    logic [31:0] imem_rdata = '0, redirect_pc = '0;
    int          n_vec = 0, n_err = 0, gnt_mode = 0, mem_lat = 0;
    bit          lat_rand = 1'b0;
    logic        m_pend = 1'b0;
    logic [31:0] m_addr = '0;
    int          m_wait = 0;

    instruction_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_fault(if_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory: one response per accepted request, 1+lat cycles after the grant cycle.
    always begin
        logic fired, rv_done;
        logic [31:0] a;
        @(posedge clk);
        fired = imem_req && imem_gnt;
        rv_done = imem_rvalid;
        a = imem_addr;
        #2;
        if (!reset_n) begin
            m_pend = 0; imem_rvalid = 0; imem_gnt = 0; imem_rdata = '0;
        end else begin
            if (rv_done) m_pend = 0;
            if (fired) begin
                m_pend = 1; m_addr = a;
                m_wait = lat_rand ? int'($urandom_range(0, 2)) : mem_lat;
            end
            if (m_pend && m_wait == 0) begin
                imem_rvalid = 1; imem_rdata = mem_word(m_addr);
            end else begin
                imem_rvalid = 0; imem_rdata = '0;
                if (m_pend) m_wait--;
            end
            imem_gnt = imem_req && (gnt_mode == 0 || (gnt_mode == 2 && $urandom_range(0, 2) != 0));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        tick();
        reset_n = 0; redirect_valid = 0; redirect_pc = '0; id_ready = 0;
        gnt_mode = 0; mem_lat = 0; lat_rand = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
    endtask

    task automatic test_reset;
        tick();
        reset_n = 0; redirect_valid = 0; id_ready = 0;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        n_vec++; if (if_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", if_instr); end
        n_vec++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", if_pc); end
        n_vec++; if (if_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", if_fault); end
    endtask

    task automatic test_basic;
        logic exp_req, exp_valid;
        logic [31:0] pc;
        apply_reset();
        id_ready = 1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            @(negedge clk);
            exp_req = (c % 2 == 0);
            exp_valid = (c >= 2 && c % 2 == 0);
            n_vec++; if (imem_req !== exp_req) begin n_err++; $display("FAIL basic_req c%0d: got %b want %b", c, imem_req, exp_req); end
            if (exp_req) begin
                n_vec++; if (imem_addr !== 32'(c * 2)) begin n_err++; $display("FAIL basic_addr c%0d: got %h want %h", c, imem_addr, 32'(c * 2)); end
            end
            n_vec++; if (if_valid !== exp_valid) begin n_err++; $display("FAIL basic_valid c%0d: got %b want %b", c, if_valid, exp_valid); end
            if (exp_valid) begin
                pc = 32'((c - 2) * 2);
                n_vec++; if (if_pc !== pc || if_instr !== mem_word(pc)) begin n_err++; $display("FAIL basic_head c%0d: got %h/%h want %h/%h", c, if_pc, if_instr, pc, mem_word(pc)); end
            end
            n_vec++; if (if_fault !== 1'b0) begin n_err++; $display("FAIL basic_fault c%0d: got %b want 0", c, if_fault); end
        end
    endtask

    task automatic test_gnt_stall;
        int fires = 0;
        apply_reset();
        id_ready = 1; gnt_mode = 1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            if (c == 3) gnt_mode = 0;
            @(negedge clk);
            if (imem_req && imem_gnt) fires++;
            if (c <= 3) begin
                n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL stall_hold c%0d: got %b/%h want 1/0", c, imem_req, imem_addr); end
            end else begin
                n_vec++; if (imem_req !== 1'b0 || imem_addr !== 32'h4) begin n_err++; $display("FAIL stall_after c%0d: got %b/%h want 0/4", c, imem_req, imem_addr); end
            end
        end
        n_vec++; if (fires != 1) begin n_err++; $display("FAIL stall_count: got %0d want 1", fires); end
    endtask

    task automatic test_backpressure;
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            if (c > 0) tick();
            id_ready = (c == 7);
            @(negedge clk);
            if (c >= 4 && c <= 7) begin
                n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_req c%0d: got %b want 0", c, imem_req); end
                n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin n_err++; $display("FAIL bp_head c%0d: got %b/%h want 1/0", c, if_valid, if_pc); end
            end
            if (c == 8) begin
                n_vec++; if (if_pc !== 32'h4 || if_instr !== mem_word(32'h4)) begin n_err++; $display("FAIL bp_pop: got %h/%h want 4/%h", if_pc, if_instr, mem_word(32'h4)); end
                n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_err++; $display("FAIL bp_next: got %b/%h want 1/8", imem_req, imem_addr); end
            end
        end
        id_ready = 0;
    endtask

    task automatic test_redirect;
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            id_ready = (c == 4);
            if (c == 4) mem_lat = 2;
            if (c == 7) mem_lat = 0;
            redirect_valid = (c == 6);
            redirect_pc = 32'h100;
            @(negedge clk);
            if (c == 5) begin
                n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || if_pc !== 32'h4) begin n_err++; $display("FAIL rd_pre: got %b/%h/%h want 1/8/4", imem_req, imem_addr, if_pc); end
            end
            if (c == 6) begin
                n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rd_req_cycle: got %b want 0", imem_req); end
            end
            if (c == 7 || c == 8) begin
                n_vec++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL rd_drain c%0d: got %b/%b want 0/0", c, if_valid, imem_req); end
            end
            if (c == 9) begin
                n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL rd_refetch: got %b/%h want 1/100", imem_req, imem_addr); end
            end
            if (c == 10) begin
                n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rd_stale: got %b want 0", if_valid); end
            end
            if (c == 11) begin
                n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== mem_word(32'h100)) begin n_err++; $display("FAIL rd_head: got %b/%h/%h want 1/100/%h", if_valid, if_pc, if_instr, mem_word(32'h100)); end
            end
        end
        redirect_valid = 0;
    endtask

    task automatic test_fault;
        apply_reset();
        id_ready = 1;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) tick();
            redirect_valid = (c == 1 || c == 12);
            redirect_pc = (c == 1) ? 32'h102 : 32'h200;
            @(negedge clk);
            if (c == 1 || c == 12) begin
                n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL flt_req_redirect c%0d: got %b want 0", c, imem_req); end
            end
            if (c >= 2 && c <= 11) begin
                n_vec++; if (imem_req !== 1'b0 || if_fault !== 1'b1 || if_valid !== 1'b0) begin n_err++; $display("FAIL flt_halt c%0d: got req %b fault %b valid %b want 0/1/0", c, imem_req, if_fault, if_valid); end
            end
            if (c == 13) begin
                n_vec++; if (if_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_err++; $display("FAIL flt_resume: got %b/%b/%h want 0/1/200", if_fault, imem_req, imem_addr); end
            end
        end
        redirect_valid = 0;
    endtask

    task automatic test_wrap;
        apply_reset();
        id_ready = 1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            redirect_valid = (c == 0);
            redirect_pc = 32'hFFFF_FFFC;
            @(negedge clk);
            if (c == 0) begin
                n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL wrap_req0: got %b want 0", imem_req); end
            end
            if (c == 1) begin
                n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_top: got %b/%h want 1/fffffffc", imem_req, imem_addr); end
            end
            if (c == 2) begin
                n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h want 0", imem_addr); end
            end
            if (c == 3) begin
                n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_req: got %b/%h want 1/0", imem_req, imem_addr); end
                n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_instr !== mem_word(32'hFFFF_FFFC)) begin n_err++; $display("FAIL wrap_head: got %b/%h/%h want 1/fffffffc/%h", if_valid, if_pc, if_instr, mem_word(32'hFFFF_FFFC)); end
            end
        end
        redirect_valid = 0;
    endtask

    // Scoreboard: decode must see consecutive PCs from the last redirect target, each with
    // the word memory holds there; requests walk the same stream; faults halt everything.
    task automatic test_random;
        logic [31:0] m_exp = 32'h0, m_req = 32'h0;
        logic        m_fault = 0, m_flush = 0;
        int          delivered = 0;
        apply_reset();
        gnt_mode = 2; lat_rand = 1;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) tick();
            id_ready = $urandom_range(0, 3) != 0;
            redirect_valid = $urandom_range(0, 15) == 0;
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 4) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
            @(negedge clk);
            if (m_flush) begin
                n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rnd_flush c%0d: got %b want 0", c, if_valid); end
            end
            n_vec++; if (if_fault !== m_fault) begin n_err++; $display("FAIL rnd_fault c%0d: got %b want %b", c, if_fault, m_fault); end
            if (m_fault || redirect_valid) begin
                n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rnd_req_block c%0d: got %b want 0", c, imem_req); end
            end
            if (imem_req === 1'b1) begin
                n_vec++; if (imem_addr !== m_req) begin n_err++; $display("FAIL rnd_addr c%0d: got %h want %h", c, imem_addr, m_req); end
            end
            if (if_valid && id_ready && !redirect_valid) begin
                n_vec++; if (if_pc !== m_exp || if_instr !== mem_word(m_exp)) begin n_err++; $display("FAIL rnd_deliver c%0d: got %h/%h want %h/%h", c, if_pc, if_instr, m_exp, mem_word(m_exp)); end
                m_exp += 32'h4;
                delivered++;
            end
            if (imem_req && imem_gnt) m_req += 32'h4;
            if (redirect_valid) begin
                m_exp = redirect_pc; m_req = redirect_pc; m_fault = redirect_pc[1:0] != 2'b00;
            end
            m_flush = redirect_valid;
        end
        tick();
        redirect_valid = 0;
        n_vec++; if (delivered < 200) begin n_err++; $display("FAIL rnd_progress: got %0d want >=200", delivered); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gnt_stall();
        test_backpressure();
        test_redirect();
        test_fault();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
